step_cmd_fifo: RTL and testbench

//  Command buffer and dispatcher upstream of the step-pulse generator.
//  - Accepts 8-bit velocity commands from the MCU bus: bit7 = dir, bits6:0 = pulses per period.
//  - Queues them in a FIFO.
//  - Issues one command at a time to the generator through N[7:0] and a WR strobe, then waits for the generator's busy to drop.
//  - Lets the MCU write several control periods ahead without polling busy.

---
 rtl/step_cmd_fifo.sv | 199 +++++++++++++++++++
 tb/tb_step_cmd_fifo.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_cmd_fifo.sv
// step_cmd_fifo: command queue and dispatcher in front of the step-pulse
// generator. MCU bytes (bit7 = dir, bits6:0 = pulses per period) are
// synchronised, queued, and then handed to the generator one at a time with
// a WR strobe. The next command is issued only after the generator's busy
// has risen and fallen again.
// Optional feature: define STEP_CMD_UNDERRUN_EN to add the sticky underrun_o
// flag, which means the queue ran dry while the motor was running.
module step_cmd_fifo #(
  parameter int DEPTH       = 8,
  parameter int AW          = 3,
  parameter int WR_HOLD     = 2,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [7:0]    host_d_i,
  input  logic          host_wr_i,
  input  logic          flush_i,
  input  logic          gen_busy_i,
  output logic [7:0]    gen_n_o,
  output logic          gen_wr_o,
  output logic [AW:0]   count_o,
  output logic          empty_o,
  output logic          full_o,
  output logic          overflow_o,
  output logic          ack_err_o
`ifdef STEP_CMD_UNDERRUN_EN
  ,
  output logic          underrun_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD     = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_RUN      = 2'd3
  } state_e;

  localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [7:0]  WR_LAST  = 8'(WR_HOLD);
  localparam logic [7:0]  ACK_LAST = 8'(ACK_TIMEOUT - 1);

  // host strobe synchroniser and edge detector
  logic s1_q, s2_q, s3_q;

  // queue storage and bookkeeping
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          overflow_q;

  // dispatcher
  state_e        state_q;
  logic [7:0]    timer_q;
  logic [7:0]    gen_n_q;
  logic          gen_wr_q;
  logic          ack_err_q;

  logic push_s, pop_s, push_ok_s, empty_s, full_s;

  assign push_s    = s2_q & ~s3_q;
  assign empty_s   = (count_q == {(AW+1){1'b0}});
  assign full_s    = (count_q == DEPTH_C);
  // A pop is exactly the IDLE->LOAD dispatch decision.
  assign pop_s     = (state_q == ST_IDLE) & ~empty_s & ~gen_busy_i;
  // A push into a full queue is still accepted if a slot frees in the same cycle.
  assign push_ok_s = push_s & (~full_s | pop_s);

  // Two-flop synchroniser for the asynchronous host strobe plus the edge flop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= host_wr_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Queue storage write; flush discards a coinciding push.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i && push_ok_s) begin
      mem_q[wr_ptr_q] <= host_d_i;
    end
  end

  // Pointers, occupancy counter and sticky overflow; flush beats push and pop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {(AW+1){1'b0}};
      overflow_q <= 1'b0;
    end else if (flush_i) begin
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {(AW+1){1'b0}};
      overflow_q <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
      if (push_s && full_s && !pop_s) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Dispatcher: issue head entry, hold WR, wait for busy to rise, then to fall.
  // Flush deliberately has no effect here so an in-flight command completes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      timer_q   <= 8'd0;
      gen_n_q   <= 8'd0;
      gen_wr_q  <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop_s) begin
            gen_n_q  <= mem_q[rd_ptr_q];
            gen_wr_q <= 1'b1;
            timer_q  <= 8'd1;
            state_q  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // timer_q counts high cycles of gen_wr, the first one included.
          if (timer_q >= WR_LAST) begin
            gen_wr_q <= 1'b0;
            timer_q  <= 8'd0;
            state_q  <= ST_WAIT_ACK;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        ST_WAIT_ACK: begin
          if (gen_busy_i) begin
            state_q <= ST_RUN;
          end else if (timer_q >= ACK_LAST) begin
            ack_err_q <= 1'b1;
            timer_q   <= 8'd0;
            state_q   <= ST_IDLE;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        ST_RUN: begin
          if (!gen_busy_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          gen_wr_q <= 1'b0;
          timer_q  <= 8'd0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef STEP_CMD_UNDERRUN_EN
  logic underrun_q;

  // Sticky underrun: the generator finished a command with nothing queued.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      underrun_q <= 1'b0;
    end else if (flush_i) begin
      underrun_q <= 1'b0;
    end else if ((state_q == ST_RUN) && !gen_busy_i && empty_s) begin
      underrun_q <= 1'b1;
    end
  end

  assign underrun_o = underrun_q;
`endif

  assign gen_n_o    = gen_n_q;
  assign gen_wr_o   = gen_wr_q;
  assign count_o    = count_q;
  assign empty_o    = empty_s;
  assign full_o     = full_s;
  assign overflow_o = overflow_q;
  assign ack_err_o  = ack_err_q;

endmodule

// File: tb/tb_step_cmd_fifo.sv
// Self-checking bench for step_cmd_fifo: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model
// (byte queue + dispatch timestamps) updated once per clock edge.
module tb_step_cmd_fifo;

  localparam int DEPTH       = 8;
  localparam int AW          = 3;
  localparam int WR_HOLD     = 2;
  localparam int ACK_TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    host_d = 8'h00;
  logic          host_wr = 1'b0;
  logic          flush = 1'b0;
  logic          gen_busy = 1'b0;
  logic [7:0]    gen_n;
  logic          gen_wr;
  logic [AW:0]   count;
  logic          empty, full, overflow, ack_err;
`ifdef STEP_CMD_UNDERRUN_EN
  logic          underrun;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // 20 MHz clock
  always #25 clk = ~clk;

  step_cmd_fifo #(
    .DEPTH(DEPTH), .AW(AW), .WR_HOLD(WR_HOLD), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk_i(clk), .rst_i(rst), .host_d_i(host_d), .host_wr_i(host_wr),
    .flush_i(flush), .gen_busy_i(gen_busy), .gen_n_o(gen_n), .gen_wr_o(gen_wr),
    .count_o(count), .empty_o(empty), .full_o(full), .overflow_o(overflow),
    .ack_err_o(ack_err)
`ifdef STEP_CMD_UNDERRUN_EN
    , .underrun_o(underrun)
`endif
  );

  // ---------------- reference model ----------------
  logic [7:0] m_q [$];
  logic [7:0] m_gen_n = 8'h00;
  bit  m_ovf = 1'b0, m_ack = 1'b0, m_und = 1'b0;
  bit  m_active = 1'b0, m_seen_busy = 1'b0;
  bit  h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;  // host_wr samples 1, 2, 3 edges back
  int  m_edge = 0, m_disp_edge = -100;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  function automatic void model_step();
    bit push, was_empty, pop;
    int sz, since_fall;
    m_edge++;
    if (rst) begin
      m_q.delete();
      m_gen_n = 8'h00; m_ovf = 1'b0; m_ack = 1'b0; m_und = 1'b0;
      m_active = 1'b0; m_seen_busy = 1'b0;
      h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
      return;
    end
    push      = h2 && !h3;
    h3 = h2; h2 = h1; h1 = host_wr;
    sz        = m_q.size();
    was_empty = (sz == 0);
    pop       = 1'b0;
    since_fall = m_edge - m_disp_edge - WR_HOLD;
    if (!m_active) begin
      if (!was_empty && !gen_busy) begin
        m_gen_n = m_q[0];
        pop = 1'b1;
        m_active = 1'b1;
        m_seen_busy = 1'b0;
        m_disp_edge = m_edge;
      end
    end else if (since_fall <= 0) begin
      // strobe still being driven; busy not looked at yet
    end else if (!m_seen_busy) begin
      if (gen_busy) m_seen_busy = 1'b1;
      else if (since_fall == ACK_TIMEOUT) begin
        m_ack = 1'b1;
        m_active = 1'b0;
      end
    end else if (!gen_busy) begin
      m_active = 1'b0;
      if (was_empty) m_und = 1'b1;
    end
    if (flush) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_und = 1'b0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (sz == DEPTH && !pop) m_ovf = 1'b1;
        else m_q.push_back(host_d);
      end
    end
  endfunction

  task automatic check_all();
    chk("gen_n", gen_n, m_gen_n);
    chk("gen_wr", gen_wr, m_active && (m_edge - m_disp_edge < WR_HOLD));
    chk("count", count, m_q.size());
    chk("empty", empty, m_q.size() == 0);
    chk("full", full, m_q.size() == DEPTH);
    chk("overflow", overflow, m_ovf);
    chk("ack_err", ack_err, m_ack);
`ifdef STEP_CMD_UNDERRUN_EN
    chk("underrun", underrun, m_und);
`endif
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic strobe(input logic [7:0] d, input int w);
    host_d = d;
    host_wr = 1'b1;
    repeat (w) cycle();
    host_wr = 1'b0;
    repeat (3) cycle();
  endtask

  task automatic wait_wr(input logic lvl, input int budget);
    int n = 0;
    while (gen_wr !== lvl && n < budget) begin
      cycle();
      n++;
    end
    chk("wait_gen_wr", gen_wr, lvl);
  endtask

  int hw_left = 0, gap_left = 0;

  initial begin
    // ---- reset ----
    rst = 1'b1;
    cycle(); cycle();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_gen_wr", gen_wr, 0);
    chk("rst_gen_n", gen_n, 8'h00);
    rst = 1'b0;

    // ---- single command ----
    gen_busy = 1'b0;
    host_d = 8'h85; host_wr = 1'b1;
    cycle(); cycle();
    host_wr = 1'b0;
    cycle();
    chk("single_push_count", count, 1);
    cycle();
    chk("single_wr_rise", gen_wr, 1);
    chk("single_gen_n", gen_n, 8'h85);
    chk("single_count0", count, 0);
    cycle();
    chk("single_wr_hold", gen_wr, 1);
    cycle();
    chk("single_wr_fall", gen_wr, 0);
    gen_busy = 1'b1;
    repeat (20) cycle();
    chk("single_no_ack_err", ack_err, 0);

    // ---- back-to-back while busy ----
    strobe(8'h10, 1);
    strobe(8'h20, 2);
    strobe(8'h30, 3);
    chk("b2b_count3", count, 3);
    for (int i = 1; i <= 3; i++) begin
      logic [7:0] exp_n;
      exp_n = 8'(i * 16);
      gen_busy = 1'b0;
      cycle();
      chk("b2b_wr_early", gen_wr, 0);
      cycle();
      chk("b2b_wr_rise", gen_wr, 1);
      chk("b2b_gen_n", gen_n, exp_n);
      gen_busy = 1'b1;
      repeat (6) cycle();
    end
    chk("b2b_count0", count, 0);

    // ---- full and overflow ----
    for (int i = 0; i < 9; i++) strobe(8'hA0 + 8'(i), 1);
    chk("ovf_count", count, 8);
    chk("ovf_full", full, 1);
    chk("ovf_flag", overflow, 1);
    flush = 1'b1; cycle(); flush = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_ovf", overflow, 0);

    // ---- push + pop at full ----
    for (int i = 0; i < 8; i++) strobe(8'hB0 + 8'(i), 1);
    chk("refill_full", full, 1);
    host_d = 8'h5A; host_wr = 1'b1;
    cycle();
    gen_busy = 1'b0;
    cycle(); cycle();
    host_wr = 1'b0;
    chk("pushpop_count", count, 8);
    chk("pushpop_ovf", overflow, 0);
    chk("pushpop_gen_n", gen_n, 8'hB0);
    gen_busy = 1'b1;
    repeat (4) cycle();

    // ---- flush + push ----
    host_d = 8'h77; host_wr = 1'b1;
    cycle(); cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0; host_wr = 1'b0;
    chk("flushpush_count", count, 0);
    repeat (3) cycle();

    // ---- ack timeout ----
    rst = 1'b1; cycle(); cycle(); rst = 1'b0;
    gen_busy = 1'b0;
    strobe(8'h42, 1);
    wait_wr(1'b0, 10);
    repeat (ACK_TIMEOUT - 1) cycle();
    chk("ack_early", ack_err, 0);
    cycle();
    chk("ack_set", ack_err, 1);
    strobe(8'h43, 1);
    chk("ack_idle_redispatch", gen_n, 8'h43);

    // ---- randomized traffic ----
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (hw_left > 0) begin
        host_wr = 1'b1;
        hw_left--;
      end else if (gap_left > 0) begin
        host_wr = 1'b0;
        gap_left--;
      end else begin
        host_d = 8'($urandom);
        host_wr = 1'b1;
        hw_left = $urandom_range(0, 3);
        gap_left = $urandom_range(1, 6);
      end
      if ($urandom_range(0, 5) == 0) gen_busy = ~gen_busy;
      flush = ($urandom_range(0, 99) == 0);
      rst = ($urandom_range(0, 799) == 0);
      cycle();
    end
    rst = 1'b0; flush = 1'b0; host_wr = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
